apb_master: RTL and testbench

- APB initiator that converts a simple valid/ready request interface into APB SETUP/ACCESS transfers. It returns each transfer's result on a one-cycle response strobe.
- It is the upstream end of the APB link in the apb2apb bridge and drives the bus that the existing slave responds on.
- Supports back-to-back transfers (ACCESS to SETUP with no IDLE cycle) and an optional ready-timeout that terminates hung transfers with an error.

---
 rtl/apb_master.sv | 171 +++++++++++++++++
 tb/tb_apb_master.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB initiator: turns a valid/ready request stream into APB SETUP/ACCESS transfers
// and returns each transfer's result on a one-cycle response strobe.
module apb_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  output logic                    sel,
  output logic                    enable,
  output logic                    write,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] strobe,
  output logic                    trnsfr,
  input  logic                    ready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    slverr
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                sel_q, sel_d;
  logic                enable_q, enable_d;
  logic                write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]   strobe_q, strobe_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                rsp_slverr_q, rsp_slverr_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_hit;
  logic                capture;

  // Expiry is the last tolerated wait cycle; ready in that same cycle still wins.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sel_q         <= 1'b0;
      enable_q      <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      strobe_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      enable_q      <= enable_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      strobe_q      <= strobe_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    enable_d      = enable_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    strobe_d      = strobe_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    req_ready     = 1'b0;
    capture       = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        capture   = req_valid;
      end
      SETUP: begin
        state_d  = ACCESS;
        enable_d = 1'b1;
      end
      ACCESS: begin
        if (ready) begin
          rsp_valid_d   = 1'b1;
          rsp_slverr_d  = slverr;
          rsp_rdata_d   = (!write_q && !slverr) ? rdata : '0;
          rsp_timeout_d = 1'b0;
          req_ready     = 1'b1;
          capture       = req_valid;
          if (!req_valid) begin
            state_d  = IDLE;
            sel_d    = 1'b0;
            enable_d = 1'b0;
          end
        end else if (timeout_hit) begin
          // Forced completion never chains into a back-to-back transfer.
          rsp_valid_d   = 1'b1;
          rsp_slverr_d  = 1'b1;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
          sel_d         = 1'b0;
          enable_d      = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        sel_d    = 1'b0;
        enable_d = 1'b0;
      end
    endcase

    if (capture) begin
      state_d  = SETUP;
      sel_d    = 1'b1;
      enable_d = 1'b0;
      write_d  = req_write;
      addr_d   = req_addr;
      wdata_d  = req_wdata;
      strobe_d = req_write ? req_strb : '0;
      cnt_d    = '0;
    end
  end

  assign trnsfr      = (state_q == ACCESS) && req_valid;
  assign sel         = sel_q;
  assign enable      = enable_q;
  assign write       = write_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign strobe      = strobe_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: bus timing checks plus a response scoreboard
// fed with expected results when each request is driven.
module tb_apb_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_strb;
  logic          rsp_valid, rsp_slverr, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          sel, enable, write, trnsfr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] strobe;
  logic          ready, slverr;
  logic [DW-1:0] rdata;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          slverr;
    logic          to;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_exp = 0;
  int   n_rsp = 0;
  int   wait_n = 0;
  int   acc_cnt = 0;
  bit   hang = 1'b0;

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .sel(sel), .enable(enable), .write(write), .addr(addr), .wdata(wdata),
    .strobe(strobe), .trnsfr(trnsfr), .ready(ready), .rdata(rdata), .slverr(slverr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic w, input logic err, input logic to, input logic [DW-1:0] rd);
    rsp_t e;
    e.rdata  = (!w && !err && !to) ? rd : '0;
    e.slverr = err | to;
    e.to     = to;
    exp_q.push_back(e);
    n_exp++;
  endtask

  // Slave: ready after wait_n wait states in ACCESS, never while hung.
  always @(negedge clk) begin
    if (sel && enable) begin
      ready = !hang && (acc_cnt == wait_n);
      acc_cnt++;
    end else begin
      ready   = 1'b0;
      acc_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_slverr", 64'(rsp_slverr), 64'(e.slverr));
        check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
      end
    end
  end

  task automatic do_xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input int wn, input logic err,
                         input logic [DW-1:0] rd);
    bit done;
    done   = 1'b0;
    wait_n = wn;
    hang   = 1'b0;
    slverr = err;
    rdata  = rd;
    push_exp(w, err, 1'b0, rd);
    check("xfer_req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_strb = s;
    step();
    req_valid = 1'b0;
    check("xfer_addr", 64'(addr), 64'(a));
    check("xfer_strobe", 64'(strobe), w ? 64'(s) : 64'd0);
    for (int k = 0; k < 50 && !done; k++) begin
      step();
      if (rsp_valid) done = 1'b1;
    end
    check("xfer_rsp_seen", 64'(done), 64'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got 0x0 expected 0x1");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; slverr = 1'b0; rdata = '0;
    step(); step();
    check("rst_sel", 64'(sel), 64'd0);
    check("rst_enable", 64'(enable), 64'd0);
    check("rst_bus", 64'({write, addr, strobe}), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_rsp", 64'({rsp_valid, rsp_slverr, rsp_timeout}), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    rst_n = 1'b1;
    step();

    // Single write, zero wait states
    wait_n = 0; slverr = 1'b0; rdata = 32'hFFFF_FFFF;
    push_exp(1'b1, 1'b0, 1'b0, rdata);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10;
    req_wdata = 32'hA5A5_0001; req_strb = 4'hF;
    step();
    req_valid = 1'b0;
    check("w_c1_sel_en", 64'({sel, enable}), 64'b10);
    check("w_c1_bus", 64'({write, addr, strobe}), 64'({1'b1, 32'h10, 4'hF}));
    check("w_c1_wdata", 64'(wdata), 64'hA5A5_0001);
    step();
    check("w_c2_sel_en", 64'({sel, enable}), 64'b11);
    step();
    check("w_c3_sel_en", 64'({sel, enable}), 64'b00);
    check("w_c3_rsp_valid", 64'(rsp_valid), 64'd1);
    step();
    check("w_c4_rsp_valid", 64'(rsp_valid), 64'd0);

    // Read with 3 wait states
    wait_n = 3; rdata = 32'h1234_5678;
    push_exp(1'b0, 1'b0, 1'b0, rdata);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_strb = 4'hF;
    step();
    req_valid = 1'b0;
    check("r_setup_en", 64'(enable), 64'd0);
    check("r_strobe", 64'(strobe), 64'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      check("r_access_en", 64'({sel, enable}), 64'b11);
      check("r_access_addr", 64'(addr), 64'h20);
      check("r_access_norsp", 64'(rsp_valid), 64'd0);
    end
    step();
    check("r_done_en", 64'(enable), 64'd0);
    check("r_done_rsp", 64'(rsp_valid), 64'd1);
    step();

    // Back-to-back writes with req_valid held
    wait_n = 0; slverr = 1'b0;
    push_exp(1'b1, 1'b0, 1'b0, rdata);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h100; req_wdata = 32'h0; req_strb = 4'h3;
    for (int i = 0; i < 3; i++) begin
      step();
      check("b2b_setup", 64'({sel, enable}), 64'b10);
      check("b2b_addr", 64'(addr), 64'(32'h100 + 32'(i * 4)));
      if (i < 2) begin
        push_exp(1'b1, 1'b0, 1'b0, rdata);
        req_addr = 32'h100 + 32'((i + 1) * 4);
        req_wdata = 32'(i + 1);
      end else begin
        req_valid = 1'b0;
      end
      step();
      check("b2b_access", 64'({sel, enable}), 64'b11);
      check("b2b_trnsfr", 64'(trnsfr), (i < 2) ? 64'd1 : 64'd0);
    end
    step();
    check("b2b_idle_sel", 64'(sel), 64'd0);
    step();

    // Slave error on read
    do_xfer(1'b0, 32'h400, 32'h0, 4'hF, 0, 1'b1, 32'h0000_DEAD);

    // Timeout with req_valid held; a queued write follows from IDLE
    hang = 1'b1; slverr = 1'b0;
    push_exp(1'b0, 1'b0, 1'b1, 32'h0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h500;
    step();
    req_write = 1'b1; req_addr = 32'h504; req_wdata = 32'h77; req_strb = 4'h1;
    for (int c = 0; c < 4; c++) begin
      step();
      check("to_access_en", 64'({sel, enable}), 64'b11);
      check("to_trnsfr", 64'(trnsfr), 64'd1);
      check("to_norsp", 64'(rsp_valid), 64'd0);
    end
    step();
    check("to_rsp_valid", 64'(rsp_valid), 64'd1);
    check("to_idle_sel", 64'({sel, enable}), 64'b00);
    check("to_idle_ready", 64'(req_ready), 64'd1);
    hang = 1'b0; wait_n = 0;
    push_exp(1'b1, 1'b0, 1'b0, rdata);
    step();
    req_valid = 1'b0;
    check("to_next_addr", 64'(addr), 64'h504);
    step(); step();
    check("to_next_rsp", 64'(rsp_valid), 64'd1);
    step();

    // Ready on the last tolerated cycle wins over timeout
    do_xfer(1'b0, 32'h600, 32'h0, 4'hF, 3, 1'b0, 32'hCAFE_0004);

    // Reset during a wait state: no response, then normal operation
    hang = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h700;
    step();
    req_valid = 1'b0;
    step(); step();
    check("rstx_pre_en", 64'(enable), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rstx_sel_en", 64'({sel, enable}), 64'b00);
    check("rstx_addr", 64'(addr), 64'd0);
    check("rstx_rsp", 64'(rsp_valid), 64'd0);
    step(); step();
    rst_n = 1'b1;
    hang = 1'b0;
    step();
    do_xfer(1'b0, 32'h800, 32'h0, 4'hF, 1, 1'b0, 32'h0BAD_F00D);

    step(); step();
    check("rsp_count", 64'(n_rsp), 64'(n_exp));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
